// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encodings and default tick divider.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10,
        ST_LAP  = 2'b11
    } sw_state_t;

    // 50 MHz system clock down to a 100 Hz count tick
    localparam int DIV_DEFAULT = 500000;

endpackage

// File: rtl/tick_div.sv
// Prescaler for the stopwatch: counts while run is high, holds otherwise, and emits
// a registered one-cycle tick the cycle after it wraps. zero forces the count back to 0.
module tick_div #(
    parameter  int DIV = 500000,
    localparam int PW  = $clog2(DIV)
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    input  logic zero,
    output logic tick
);

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= run && (pre == LAST);
            if (zero)
                pre <= '0;
            else if (run)
                pre <= (pre == LAST) ? '0 : pre + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns start/stop and lap/reset pulses into EN, CLR and LAP_HOLD.
// Optional manual preset increment is enabled by defining STOPWATCH_ADJ_EN.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SS,
    input  logic       LR,
    input  logic       ADJ,
    output logic       EN,
    output logic       INC,
    output logic       CLR,
    output logic       LAP_HOLD,
    output logic [1:0] STATE
);

    sw_state_t state, nxt;
    logic      counting;
    logic      clr_req;

    // SS always takes priority; LR only acts when SS is absent
    always_comb begin
        nxt     = state;
        clr_req = 1'b0;
        unique case (state)
            ST_IDLE: if (SS) nxt = ST_RUN;
            ST_RUN:  if (SS) nxt = ST_STOP; else if (LR) nxt = ST_LAP;
            ST_LAP:  if (SS) nxt = ST_STOP; else if (LR) nxt = ST_RUN;
            ST_STOP: begin
                if (SS) nxt = ST_RUN;
                else if (LR) begin
                    nxt     = ST_IDLE;
                    clr_req = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            CLR      <= 1'b0;
            LAP_HOLD <= 1'b0;
        end else begin
            state    <= nxt;
            CLR      <= clr_req;
            LAP_HOLD <= (nxt == ST_LAP);
        end
    end

    assign STATE    = state;
    assign counting = (state == ST_RUN) || (state == ST_LAP);

    // Zeroing on the next-state keeps the STOP->IDLE edge clearing the phase too
    tick_div #(.DIV(DIV)) u_div (
        .CLK  (CLK),
        .RST  (RST),
        .run  (counting),
        .zero (nxt == ST_IDLE),
        .tick (EN)
    );

`ifdef STOPWATCH_ADJ_EN
    always_ff @(posedge CLK) begin
        if (RST)
            INC <= 1'b0;
        else
            INC <= ADJ && ((state == ST_IDLE) || (state == ST_STOP)) && !clr_req;
    end
`else
    logic adj_unused;
    assign adj_unused = ADJ;
    assign INC        = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (DIV=4): vector table plus scoreboard against a
// cycle model, with hand-written sequences for tick timing and clear-to-restart latency.
module tb_stopwatch_ctrl;

    localparam int DIV = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SS  = 1'b0;
    logic       LR  = 1'b0;
    logic       ADJ = 1'b0;
    logic       EN, INC, CLR, LAP_HOLD;
    logic [1:0] STATE;

    stopwatch_ctrl #(.DIV(DIV)) dut (
        .CLK(CLK), .RST(RST), .SS(SS), .LR(LR), .ADJ(ADJ),
        .EN(EN), .INC(INC), .CLR(CLR), .LAP_HOLD(LAP_HOLD), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       en, inc, clr, lap;
        logic [1:0] st;
    } exp_t;

    typedef struct {
        logic       rst, ss, lr, adj;
        int         hold;
        logic [1:0] exp_state;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // reference model state
    logic [1:0] m_st  = 2'b00;
    int         m_pre = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic l, input logic a);
        exp_t       e;
        logic [1:0] n;
        logic       cnt;
        RST = r; SS = s; LR = l; ADJ = a;
        cnt = (m_st == 2'b01) || (m_st == 2'b11);
        if (r) begin
            e = '{en:1'b0, inc:1'b0, clr:1'b0, lap:1'b0, st:2'b00};
            m_st = 2'b00; m_pre = 0;
        end else begin
            n = m_st;
            if (s) begin
                case (m_st)
                    2'b00: n = 2'b01;
                    2'b01: n = 2'b10;
                    2'b11: n = 2'b10;
                    default: n = 2'b01;
                endcase
            end else if (l) begin
                case (m_st)
                    2'b01: n = 2'b11;
                    2'b11: n = 2'b01;
                    2'b10: n = 2'b00;
                    default: n = m_st;
                endcase
            end
            e.en  = cnt && (m_pre == DIV - 1);
            e.clr = (m_st == 2'b10) && l && !s;
            e.lap = (n == 2'b11);
            e.st  = n;
`ifdef STOPWATCH_ADJ_EN
            e.inc = a && ((m_st == 2'b00) || (m_st == 2'b10)) && !e.clr;
`else
            e.inc = 1'b0;
`endif
            if (n == 2'b00)      m_pre = 0;
            else if (cnt)        m_pre = (m_pre == DIV - 1) ? 0 : m_pre + 1;
            m_st = n;
        end
        q.push_back(e);
        @(posedge CLK);
        #1;
        cyc++;
        e = q.pop_front();
        chk("state",    int'(STATE),    int'(e.st));
        chk("en",       int'(EN),       int'(e.en));
        chk("clr",      int'(CLR),      int'(e.clr));
        chk("lap_hold", int'(LAP_HOLD), int'(e.lap));
        chk("inc",      int'(INC),      int'(e.inc));
        chk("en_clr_excl", int'(EN && CLR), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t vecs[18];
    int   waited;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 2'b10};  // RUN -> STOP
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5, 2'b01};  // resume, phase held
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9, 2'b11};  // lap, still counting
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 2'b01};  // lap release
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 2'b10};  // SS beats LR
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3, 2'b00};  // LR beats ADJ in STOP
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 2'b00};  // ADJ in IDLE
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6, 2'b01};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 2'b01};  // ADJ ignored in RUN
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 2'b10};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 2'b10};  // ADJ in STOP
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 2'b00};  // clear
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 2'b00};  // LR ignored in IDLE
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 5, 2'b01};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 2'b00};  // reset mid-run
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 2'b01};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 6, 2'b11};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 2'b10};  // SS from LAP

        // reset, SS sampled at edge 3; EN expected exactly at cycles 7, 11, 15
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_state", int'(STATE), 0);
        chk("reset_outs",  int'({EN, INC, CLR, LAP_HOLD}), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("run_at_3", int'(STATE), 1);
        for (int c = 4; c <= 16; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("en_cadence", int'(EN), (c == 7 || c == 11 || c == 15) ? 1 : 0);
        end

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ss, vecs[i].lr, vecs[i].adj);
            chk("vec_state", int'(STATE), int'(vecs[i].exp_state));
            idle(vecs[i].hold);
        end

        // STOP -> LR -> IDLE with one CLR cycle, then SS: first EN exactly 4 cycles later
        step(1'b0, 1'b1, 1'b0, 1'b0);   // STOP -> RUN
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b0);   // RUN -> STOP with nonzero phase
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_pulse", int'(CLR), 1);
        chk("idle_after_clr", int'(STATE), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_single", int'(CLR), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        waited = 0;
        while (!EN && waited < 10) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            waited++;
        end
        chk("first_en_latency", waited, 4);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("en_single", int'(EN), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
